// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, helpers.
// Pure declarations, no logic; imported by md_core, md_unit and the control path.
// No flow control here; see md_unit for busy/cancel behaviour.
package md_pkg;

  localparam int MD_OP_WIDTH = 3;

  typedef enum logic [MD_OP_WIDTH-1:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // Codes 6 and 7 are unassigned.
  function automatic logic md_op_is_invalid(input logic [MD_OP_WIDTH-1:0] op);
    return (op > MD_MTLO);
  endfunction

endpackage

// File: rtl/md_core.sv
// Combinational multiply/divide datapath: op, num1, num2 -> {res_hi, res_lo}.
// Zero latency; md_unit models the multi-cycle timing around it.
// No backpressure; result is valid whenever inputs are stable.
module md_core
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [MD_OP_WIDTH-1:0] i_op,
  input  logic [WIDTH-1:0]       i_num1,
  input  logic [WIDTH-1:0]       i_num2,
  output logic [WIDTH-1:0]       o_res_hi,
  output logic [WIDTH-1:0]       o_res_lo
);

  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL1    = {WIDTH{1'b1}};

  logic [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0] w_prod_u;
  logic               w_div_zero;
  logic               w_div_ovf;
  logic [WIDTH-1:0]   w_den;
  logic [WIDTH-1:0]   w_q_s;
  logic [WIDTH-1:0]   w_r_s;
  logic [WIDTH-1:0]   w_q_u;
  logic [WIDTH-1:0]   w_r_u;

  // Operands are widened explicitly so the product never depends on context sizing.
  assign w_prod_s = $signed({{WIDTH{i_num1[WIDTH-1]}}, i_num1}) *
                    $signed({{WIDTH{i_num2[WIDTH-1]}}, i_num2});
  assign w_prod_u = {{WIDTH{1'b0}}, i_num1} * {{WIDTH{1'b0}}, i_num2};

  // A zero divisor is replaced by one so the divider never sees it; the
  // result is overridden below anyway.
  assign w_div_zero = (i_num2 == '0);
  assign w_div_ovf  = (i_num1 == MIN_INT) && (i_num2 == ALL1);
  assign w_den      = w_div_zero ? ONE : i_num2;

  // SystemVerilog signed / and % truncate toward zero, remainder takes dividend sign.
  assign w_q_s = $signed(i_num1) / $signed(w_den);
  assign w_r_s = $signed(i_num1) % $signed(w_den);
  assign w_q_u = i_num1 / w_den;
  assign w_r_u = i_num1 % w_den;

  // Select the result pair for the requested op; move ops produce nothing here.
  always_comb begin
    o_res_hi = '0;
    o_res_lo = '0;
    case (i_op)
      MD_MULT: begin
        o_res_hi = w_prod_s[2*WIDTH-1:WIDTH];
        o_res_lo = w_prod_s[WIDTH-1:0];
      end
      MD_MULTU: begin
        o_res_hi = w_prod_u[2*WIDTH-1:WIDTH];
        o_res_lo = w_prod_u[WIDTH-1:0];
      end
      MD_DIV: begin
        if (w_div_zero) begin
          o_res_hi = i_num1;
          o_res_lo = ALL1;
        end else if (w_div_ovf) begin
          o_res_hi = '0;
          o_res_lo = MIN_INT;
        end else begin
          o_res_hi = w_r_s;
          o_res_lo = w_q_s;
        end
      end
      MD_DIVU: begin
        if (w_div_zero) begin
          o_res_hi = i_num1;
          o_res_lo = ALL1;
        end else begin
          o_res_hi = w_r_u;
          o_res_lo = w_q_u;
        end
      end
      default: begin
        o_res_hi = '0;
        o_res_lo = '0;
      end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers and cancel support.
// mult/multu busy MULT_CYCLES, div/divu busy DIV_CYCLES; mthi/mtlo write in one edge.
// No internal queueing: starts while busy are dropped, control must stall on busy.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [MD_OP_WIDTH-1:0] op,
  input  logic [WIDTH-1:0]       num1,
  input  logic [WIDTH-1:0]       num2,
  input  logic                   cancel,
  output logic                   busy,
  output logic [WIDTH-1:0]       hi,
  output logic [WIDTH-1:0]       lo,
  output logic                   op_invalid
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  md_state_e        r_state;
  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_pend_hi;
  logic [WIDTH-1:0] r_pend_lo;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;
  logic             w_launch;

  md_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .i_op     (op),
    .i_num1   (num1),
    .i_num2   (num2),
    .o_res_hi (w_res_hi),
    .o_res_lo (w_res_lo)
  );

  // A start is only honoured from idle and only if not squashed in the same cycle.
  assign w_launch = start && !cancel && (r_state == ST_IDLE);

  // Invalid-op flag reflects the decoded op whenever start is raised, busy or not.
  assign op_invalid = start && md_op_is_invalid(op);

  // IDLE/RUN controller: loads operands' result, counts down, commits or cancels.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_cnt     <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            case (op)
              MD_MULT, MD_MULTU: begin
                r_pend_hi <= w_res_hi;
                r_pend_lo <= w_res_lo;
                r_cnt     <= MULT_LOAD;
                r_state   <= ST_RUN;
                r_busy    <= 1'b1;
              end
              MD_DIV, MD_DIVU: begin
                r_pend_hi <= w_res_hi;
                r_pend_lo <= w_res_lo;
                r_cnt     <= DIV_LOAD;
                r_state   <= ST_RUN;
                r_busy    <= 1'b1;
              end
              MD_MTHI: r_hi <= num1;
              MD_MTLO: r_lo <= num1;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (cancel) begin
            // Squash beats commit, even on the last busy cycle.
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
          end else if (r_cnt == '0) begin
            r_hi    <= r_pend_hi;
            r_lo    <= r_pend_lo;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: reset, mult/div results and latency, busy-start,
// cancel, reset mid-op, mthi/mtlo and invalid op.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_md_unit;
  import md_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  num1;
  logic [W-1:0]  num2;
  logic          cancel;
  logic          busy;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic          op_invalid;

  int n_checks = 0;
  int n_errors = 0;

  md_unit #(
    .WIDTH       (W),
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .num1       (num1),
    .num2       (num2),
    .cancel     (cancel),
    .busy       (busy),
    .hi         (hi),
    .lo         (lo),
    .op_invalid (op_invalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a start for one cycle; afterwards we sit in the first busy cycle.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op    = o;
    num1  = a;
    num2  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Count cycles in which busy is observed high, bounded.
  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
    if (n >= 200) chk({tag, "_timeout"}, 64'(busy), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] o,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input int cyc, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    int n;
    issue(o, a, b);
    wait_done(tag, n);
    chk({tag, "_cycles"}, 64'(n), 64'(cyc));
    chk({tag, "_hi"}, 64'(hi), 64'(ehi));
    chk({tag, "_lo"}, 64'(lo), 64'(elo));
  endtask

  initial begin
    int n;
    int m;
    rst = 1'b1; start = 1'b0; op = '0; num1 = '0; num2 = '0; cancel = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // 1: reset then idle
    tick(); tick(); tick();
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_inv", 64'(op_invalid), 64'd0);

    // 2: multiply
    run_op("mult",  3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 5, 32'h0000_0001, 32'hFFFF_FFFE);

    // 3: divide, incl. div-by-zero and overflow corner
    run_op("div_m7_2",  3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_m2",  3'd2, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);
    run_op("divu_7_0",  3'd3, 32'd7, 32'd0, 10, 32'd7, 32'hFFFF_FFFF);
    run_op("div_ovf",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
    run_op("divu_big",  3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'd1, 32'h7FFF_FFFC);

    // 4a: second mult issued in busy cycle 2 is ignored
    issue(3'd0, 32'd4, 32'd5);          // busy cycle 1
    tick();                             // busy cycle 2
    op = 3'd0; num1 = 32'd3; num2 = 32'd3; start = 1'b1;
    tick();                             // busy cycle 3
    start = 1'b0;
    wait_done("busy_start", m);
    chk("busy_start_cycles", 64'(2 + m), 64'd5);
    chk("busy_start_hi", 64'(hi), 64'd0);
    chk("busy_start_lo", 64'(lo), 64'd20);

    // 4b: mthi while busy does not write hi
    issue(3'd0, 32'd6, 32'd7);
    tick();
    op = 3'd4; num1 = 32'h1234; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("busy_mthi", m);
    chk("busy_mthi_cycles", 64'(2 + m), 64'd5);
    chk("busy_mthi_hi", 64'(hi), 64'd0);
    chk("busy_mthi_lo", 64'(lo), 64'd42);

    // 5a: cancel on the last div busy cycle beats the commit
    issue(3'd3, 32'd100, 32'd7);        // busy cycle 1
    for (int i = 0; i < 9; i++) tick(); // busy cycle 10
    chk("cancel_busy_c10", 64'(busy), 64'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_busy", 64'(busy), 64'd0);
    chk("cancel_hi", 64'(hi), 64'd0);
    chk("cancel_lo", 64'(lo), 64'd42);
    tick(); tick();
    chk("cancel_lo_hold", 64'(lo), 64'd42);

    // 5b: cancel with start while idle suppresses the start
    op = 3'd1; num1 = 32'd9; num2 = 32'd9; start = 1'b1; cancel = 1'b1;
    tick();
    start = 1'b0; cancel = 1'b0;
    chk("cancel_start_busy", 64'(busy), 64'd0);
    tick(); tick(); tick(); tick(); tick(); tick();
    chk("cancel_start_lo", 64'(lo), 64'd42);

    // 5c: reset mid-mult
    issue(3'd0, 32'd3, 32'd3);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    for (int i = 0; i < 6; i++) tick();
    chk("midrst_lo_later", 64'(lo), 64'd0);

    // 6: mthi/mtlo while idle
    issue(3'd4, 32'h5555, 32'd0);
    chk("mthi_hi", 64'(hi), 64'h5555);
    chk("mthi_busy", 64'(busy), 64'd0);
    issue(3'd5, 32'hABCD, 32'd0);
    chk("mtlo_lo", 64'(lo), 64'hABCD);
    chk("mtlo_hi", 64'(hi), 64'h5555);
    chk("mtlo_busy", 64'(busy), 64'd0);

    // 6b: invalid op
    op = 3'd7; num1 = 32'hDEAD; num2 = 32'd1; start = 1'b1;
    #1;
    chk("inv_flag", 64'(op_invalid), 64'd1);
    tick();
    start = 1'b0;
    #1;
    chk("inv_flag_clr", 64'(op_invalid), 64'd0);
    chk("inv_busy", 64'(busy), 64'd0);
    chk("inv_hi", 64'(hi), 64'h5555);
    chk("inv_lo", 64'(lo), 64'hABCD);
    op = 3'd6; start = 1'b1;
    #1;
    chk("inv6_flag", 64'(op_invalid), 64'd1);
    start = 1'b0;
    #1;
    chk("valid_op_flag", 64'(op_invalid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
